// File: rtl/dmem_pkg.sv
// Shared types, constants and lane helper for the memory-stage data-access controller.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } dmem_state_t;

    localparam logic [3:0]  BE_WORD     = 4'b1111;
    localparam logic [31:0] FAULT_RDATA = 32'h0;

    // One-hot lane for a byte access, all four lanes for a word access.
    function automatic logic [3:0] lane_be(input logic [1:0] addr, input logic byte_acc);
        return byte_acc ? (4'b0001 << addr) : BE_WORD;
    endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Combinational byte-lane formatting: store-side enables and data replication,
// load-side lane extraction with zero-extension.
module dmem_lane_fmt
    import dmem_pkg::*;
(
    input  logic [1:0]  st_lane,
    input  logic        st_byte,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [1:0]  ld_lane,
    input  logic        ld_byte,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [7:0] ld_lane_byte;

    always_comb begin
        st_be    = lane_be(st_lane, st_byte);
        st_wdata = st_byte ? {4{st_data[7:0]}} : st_data;

        case (ld_lane)
            2'd0:    ld_lane_byte = ld_rdata[7:0];
            2'd1:    ld_lane_byte = ld_rdata[15:8];
            2'd2:    ld_lane_byte = ld_rdata[23:16];
            default: ld_lane_byte = ld_rdata[31:24];
        endcase

        ld_data = ld_byte ? {24'h0, ld_lane_byte} : ld_rdata;
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// M-stage data-access controller: pipeline load/store -> req/ack bus handshake with StallM.
// Optional posted write buffer enabled by defining DMEM_WRITE_BUFFER_EN.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic              ByteM,
    input  logic [ADDR_W-1:0] ALUOutM,
    input  logic [DATA_W-1:0] WriteDataM,
    output logic [DATA_W-1:0] ReadDataM,
    output logic              StallM,
    output logic              DFault,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [3:0]        bus_be,
    input  logic              bus_ack,
    input  logic              bus_err,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam int              CNT_W       = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    dmem_state_t      state;
    logic [CNT_W-1:0] wait_cnt;
    logic             acc_byte;
    logic [1:0]       acc_lane;
    logic             request;
    logic [3:0]       st_be;
    logic [31:0]      st_wdata;
    logic [31:0]      ld_data;
`ifdef DMEM_WRITE_BUFFER_EN
    logic             posted;
`endif

    assign request = MemReadM | MemWriteM;

    dmem_lane_fmt u_lane_fmt (
        .st_lane  (ALUOutM[1:0]),
        .st_byte  (ByteM),
        .st_data  (WriteDataM),
        .st_be    (st_be),
        .st_wdata (st_wdata),
        .ld_lane  (acc_lane),
        .ld_byte  (acc_byte),
        .ld_rdata (bus_rdata),
        .ld_data  (ld_data)
    );

    // A posted store releases the pipeline at once; anything behind it waits for the drain.
    always_comb begin
        StallM = 1'b0;
        case (state)
`ifdef DMEM_WRITE_BUFFER_EN
            IDLE:    StallM = MemReadM & ~MemWriteM;
            BUSY:    StallM = posted ? request : 1'b1;
`else
            IDLE:    StallM = request;
            BUSY:    StallM = 1'b1;
`endif
            default: StallM = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ReadDataM <= '0;
            DFault    <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_be    <= '0;
            wait_cnt  <= '0;
            acc_byte  <= 1'b0;
            acc_lane  <= 2'b00;
`ifdef DMEM_WRITE_BUFFER_EN
            posted    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (request) begin
                        bus_req   <= 1'b1;
                        bus_we    <= MemWriteM;
                        bus_addr  <= ByteM ? ALUOutM : {ALUOutM[ADDR_W-1:2], 2'b00};
                        bus_wdata <= st_wdata;
                        bus_be    <= st_be;
                        acc_byte  <= ByteM;
                        acc_lane  <= ALUOutM[1:0];
                        wait_cnt  <= '0;
`ifdef DMEM_WRITE_BUFFER_EN
                        posted    <= MemWriteM;
`endif
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    // An ack arriving on the last allowed cycle still wins over the timeout.
                    if (bus_ack || wait_cnt == TIMEOUT_CNT) begin
                        bus_req  <= 1'b0;
                        wait_cnt <= '0;
                        if (bus_ack) begin
                            if (!bus_we) ReadDataM <= ld_data;
                            if (bus_err) DFault <= 1'b1;
                        end else begin
                            DFault <= 1'b1;
                            if (!bus_we) ReadDataM <= FAULT_RDATA;
                        end
`ifdef DMEM_WRITE_BUFFER_EN
                        posted <= 1'b0;
                        state  <= posted ? IDLE : DONE;
`else
                        state  <= DONE;
`endif
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed cases plus randomized traffic against a memory model.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReadM, MemWriteM, ByteM;
    logic [31:0] ALUOutM, WriteDataM, ReadDataM;
    logic        StallM, DFault;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0, bus_err = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    int checks = 0;
    int failures = 0;

    // Responder controls
    int          ack_delay = 1;
    bit          ack_enable = 1'b1;
    bit          err_next = 1'b0;
    bit          use_fixed = 1'b0;
    logic [31:0] fixed_rdata = 32'h0;
    int          req_cycles = 0;

    logic [31:0] bus_mem [16];
    logic [31:0] ref_mem [16];

    // Monitor of bus transactions
    bit          prev_req = 1'b0;
    logic        last_we;
    logic [31:0] last_addr, last_wdata;
    logic [3:0]  last_be;
    bit          bus_order [$];

    dmem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .ByteM      (ByteM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .DFault     (DFault),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_be     (bus_be),
        .bus_ack    (bus_ack),
        .bus_err    (bus_err),
        .bus_rdata  (bus_rdata)
    );

    always #5 clk = ~clk;

    // Variable-latency memory: acks in the ack_delay-th cycle of a request.
    always @(negedge clk) begin
        bus_ack = 1'b0;
        bus_err = 1'b0;
        if (bus_req) begin
            if (ack_enable && req_cycles + 1 == ack_delay) begin
                bus_ack   = 1'b1;
                bus_err   = err_next;
                bus_rdata = use_fixed ? fixed_rdata : bus_mem[bus_addr[5:2]];
                if (bus_we)
                    for (int i = 0; i < 4; i++)
                        if (bus_be[i]) bus_mem[bus_addr[5:2]][8*i +: 8] = bus_wdata[8*i +: 8];
                req_cycles = 0;
            end else begin
                req_cycles++;
            end
        end else begin
            req_cycles = 0;
        end
    end

    always @(negedge clk) begin
        if (bus_req && !prev_req) begin
            last_we    = bus_we;
            last_addr  = bus_addr;
            last_be    = bus_be;
            last_wdata = bus_wdata;
            bus_order.push_back(bus_we);
        end
        prev_req = bus_req;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic init_mems();
        for (int i = 0; i < 16; i++) begin
            bus_mem[i] = $urandom;
            ref_mem[i] = bus_mem[i];
        end
    endtask

    // Presents one M-stage access and holds it until StallM releases.
    task automatic applyStimulus(input bit wr, input bit rd, input bit byt, input logic [31:0] addr,
                                 input logic [31:0] wd, output int stall, output logic [31:0] rdata);
        @(posedge clk); #1;
        MemReadM = rd; MemWriteM = wr; ByteM = byt; ALUOutM = addr; WriteDataM = wd;
        stall = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!StallM) break;
            stall++;
        end
        checkOutput("stall_bound", {31'h0, StallM}, 32'h0);
        rdata = ReadDataM;
        @(posedge clk); #1;
        MemReadM = 1'b0; MemWriteM = 1'b0; ByteM = 1'b0;
    endtask

    task automatic wait_quiet();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!bus_req) break;
        end
        checkOutput("quiet_bound", {31'h0, bus_req}, 32'h0);
    endtask

    initial begin
        int          stall;
        logic [31:0] rdata;
        logic [31:0] exp_data;
        bit          wr, byt;
        logic [31:0] addr, wd;
        int          idx, lane;

        reset = 1'b1;
        MemReadM = 1'b0; MemWriteM = 1'b0; ByteM = 1'b0; ALUOutM = '0; WriteDataM = '0;
        init_mems();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_stall",  {31'h0, StallM},  32'h0);
        checkOutput("rst_req",    {31'h0, bus_req}, 32'h0);
        checkOutput("rst_fault",  {31'h0, DFault},  32'h0);
        checkOutput("rst_rdata",  ReadDataM,        32'h0);
        checkOutput("rst_addr",   bus_addr,         32'h0);
        checkOutput("rst_be",     {28'h0, bus_be},  32'h0);
        checkOutput("rst_wdata",  bus_wdata,        32'h0);
        @(posedge clk); #1 reset = 1'b0;

        // Word load, ack in the third bus cycle
        use_fixed = 1'b1; fixed_rdata = 32'hCAFEF00D; ack_delay = 3;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h104, 32'h0, stall, rdata);
        checkOutput("wload_stall", stall, 4);
        checkOutput("wload_data", rdata, 32'hCAFEF00D);
        checkOutput("wload_addr", last_addr, 32'h104);
        checkOutput("wload_be", {28'h0, last_be}, 32'hF);
        checkOutput("wload_we", {31'h0, last_we}, 32'h0);

        // Byte store to lane 3
        ack_delay = 1;
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h203, 32'h000000A5, stall, rdata);
        wait_quiet();
`ifdef DMEM_WRITE_BUFFER_EN
        checkOutput("bstore_stall", stall, 0);
`else
        checkOutput("bstore_stall", stall, 2);
`endif
        checkOutput("bstore_be", {28'h0, last_be}, 32'h8);
        checkOutput("bstore_wdata", last_wdata, 32'hA5A5A5A5);
        checkOutput("bstore_we", {31'h0, last_we}, 32'h1);
        checkOutput("bstore_addr", last_addr, 32'h203);
        checkOutput("bstore_keeps_rdata", ReadDataM, 32'hCAFEF00D);

        // Byte load from lane 1, minimum latency
        fixed_rdata = 32'h11223344;
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h11, 32'h0, stall, rdata);
        checkOutput("bload_stall", stall, 2);
        checkOutput("bload_data", rdata, 32'h00000033);
        checkOutput("bload_be", {28'h0, last_be}, 32'h2);
        checkOutput("bload_addr", last_addr, 32'h11);

        // Word access with an unaligned address goes out aligned
        fixed_rdata = 32'h89ABCDEF;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_0457, 32'h0, stall, rdata);
        checkOutput("align_addr", last_addr, 32'h454);
        checkOutput("align_data", rdata, 32'h89ABCDEF);

        // Timeout: no ack ever arrives
        ack_enable = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, stall, rdata);
        checkOutput("tmo_stall", stall, 10);
        checkOutput("tmo_fault", {31'h0, DFault}, 32'h1);
        checkOutput("tmo_rdata", rdata, 32'h0);

        // Reset two cycles into BUSY abandons the access and clears the fault
        @(posedge clk); #1 MemReadM = 1'b1; ALUOutM = 32'h80;
        @(posedge clk);
        @(posedge clk); #1;
        checkOutput("pre_rst_fault", {31'h0, DFault}, 32'h1);
        checkOutput("pre_rst_req", {31'h0, bus_req}, 32'h1);
        reset = 1'b1; MemReadM = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midrst_req", {31'h0, bus_req}, 32'h0);
        checkOutput("midrst_stall", {31'h0, StallM}, 32'h0);
        checkOutput("midrst_fault", {31'h0, DFault}, 32'h0);
        checkOutput("midrst_rdata", ReadDataM, 32'h0);
        @(posedge clk); #1 reset = 1'b0; ack_enable = 1'b1;

        // Bus error sets the sticky fault, data still returned
        err_next = 1'b1; ack_delay = 2; fixed_rdata = 32'h0BADF00D;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h60, 32'h0, stall, rdata);
        checkOutput("err_stall", stall, 3);
        checkOutput("err_fault", {31'h0, DFault}, 32'h1);
        err_next = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h64, 32'h0, stall, rdata);
        checkOutput("fault_sticky", {31'h0, DFault}, 32'h1);
        checkOutput("post_err_data", rdata, 32'h0BADF00D);

        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        use_fixed = 1'b0;
        init_mems();

`ifdef DMEM_WRITE_BUFFER_EN
        // Posted store followed immediately by a load of the same word
        bus_order.delete();
        ack_delay = 2;
        @(posedge clk); #1;
        MemWriteM = 1'b1; ByteM = 1'b0; ALUOutM = 32'h240; WriteDataM = 32'h5A5A0001;
        @(negedge clk);
        checkOutput("wb_store_stall", {31'h0, StallM}, 32'h0);
        @(posedge clk); #1;
        MemWriteM = 1'b0; MemReadM = 1'b1; ALUOutM = 32'h240;
        ref_mem[0] = 32'h5A5A0001;
        stall = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!StallM) break;
            stall++;
        end
        checkOutput("wb_load_stall", stall, 5);
        checkOutput("wb_load_data", ReadDataM, 32'h5A5A0001);
        @(posedge clk); #1 MemReadM = 1'b0;
        wait_quiet();
        checkOutput("wb_order_len", bus_order.size(), 2);
        if (bus_order.size() == 2) begin
            checkOutput("wb_order_first", {31'h0, bus_order[0]}, 32'h1);
            checkOutput("wb_order_second", {31'h0, bus_order[1]}, 32'h0);
        end
`endif

        // Randomized traffic against a byte-addressed reference memory
        for (int n = 0; n < 40; n++) begin
            wr   = $urandom_range(0, 1);
            byt  = $urandom_range(0, 1);
            addr = 32'h300 + $urandom_range(0, 63);
            wd   = $urandom;
            ack_delay = $urandom_range(1, 4);
            idx  = int'(addr[5:2]);
            lane = int'(addr[1:0]);
            applyStimulus(wr, !wr, byt, addr, wd, stall, rdata);
            wait_quiet();
            if (wr) begin
                if (byt) ref_mem[idx][8*lane +: 8] = wd[7:0];
                else     ref_mem[idx] = wd;
`ifndef DMEM_WRITE_BUFFER_EN
                checkOutput("rnd_store_stall", stall, 1 + ack_delay);
`endif
            end else begin
                exp_data = byt ? ((ref_mem[idx] >> (8*lane)) & 32'hFF) : ref_mem[idx];
                checkOutput("rnd_load_data", rdata, exp_data);
                checkOutput("rnd_load_stall", stall, 1 + ack_delay);
            end
        end
        checkOutput("rnd_no_fault", {31'h0, DFault}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
